// File: rtl/instr_arb_pkg.sv
// Shared types for the instruction memory arbiter: port identifiers and
// arbiter FSM states.
package instr_arb_pkg;

  typedef enum logic {
    PORT_CORE   = 1'b0,
    PORT_LOADER = 1'b1
  } port_e;

  typedef enum logic {
    ST_RR      = 1'b0,
    ST_P1_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The requester that was not granted last
// wins a tie; after reset the core port holds priority.
module rr_arb2
  import instr_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  port_e last_q, last_d;

  always_comb begin
    gnt0_o = req0_i & (~req1_i | (last_q == PORT_LOADER));
    gnt1_o = req1_i & ~gnt0_o;
    last_d = last_q;
    if (gnt1_o) begin
      last_d = PORT_LOADER;
    end else if (gnt0_o) begin
      last_d = PORT_CORE;
    end
  end

  // Seeding last-grant with the loader gives the core first priority
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_LOADER;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Two-port arbiter in front of the single-ported instruction RAM wrapper:
// core fetch (port 0) versus loader/debug (port 1) with burst locking.
module instr_mem_arbiter
  import instr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  input  logic                    p1_lock_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int BE_W  = DATA_WIDTH / 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(MAX_BURST)) begin
      return CNT_W'(MAX_BURST);
    end
    return v + CNT_W'(1);
  endfunction

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rsp_vld_q, rsp_vld_d;
  port_e            rsp_owner_q, rsp_owner_d;
  logic             arb_req0, arb_req1;
  logic             gnt0, gnt1;

  // Lock ownership hides the core request; reset hides both
  assign arb_req0 = p0_req_i & ~rst & (state_q == ST_RR);
  assign arb_req1 = p1_req_i & ~rst;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req0_i (arb_req0),
    .req1_i (arb_req1),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign p0_gnt_o    = gnt0;
  assign p1_gnt_o    = gnt1;
  assign mem_en_o    = gnt0 | gnt1;
  assign mem_addr_o  = gnt1 ? p1_addr_i : p0_addr_i;
  assign mem_we_o    = gnt1 & p1_we_i;
  assign mem_be_o    = gnt1 ? p1_be_i : {BE_W{1'b1}};
  assign mem_wdata_o = gnt1 ? p1_wdata_i : '0;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    rsp_vld_d   = gnt0 | gnt1;
    rsp_owner_d = gnt1 ? PORT_LOADER : PORT_CORE;
    case (state_q)
      ST_RR: begin
        if (gnt1 && p1_lock_i) begin
          state_d     = ST_P1_LOCK;
          burst_cnt_d = '0;
        end
      end
      ST_P1_LOCK: begin
        // Only grants that actually stall the core count against the burst
        if (gnt1 && p0_req_i) begin
          burst_cnt_d = sat_inc(burst_cnt_q);
        end
        if (!p1_lock_i) begin
          state_d = ST_RR;
        end else if (p0_req_i && (burst_cnt_d == CNT_W'(MAX_BURST))) begin
          state_d = ST_RR;
        end
      end
      default: state_d = ST_RR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RR;
      burst_cnt_q <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= PORT_CORE;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // A response in flight when reset arrives is dropped, not delivered
  assign p0_rvalid_o = rsp_vld_q & ~rst & (rsp_owner_q == PORT_CORE);
  assign p1_rvalid_o = rsp_vld_q & ~rst & (rsp_owner_q == PORT_LOADER);
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;
  assign busy_o      = p0_rvalid_o | p1_rvalid_o;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: streaming fetch, round-robin, lock
// bursts, reset during a response and a boot-region read.
module tb_instr_mem_arbiter;

  logic        clk, rst;
  logic        p0_req_i, p0_gnt_o, p0_rvalid_o;
  logic [15:0] p0_addr_i;
  logic [31:0] p0_rdata_o;
  logic        p1_req_i, p1_we_i, p1_lock_i, p1_gnt_o, p1_rvalid_o;
  logic [15:0] p1_addr_i;
  logic [3:0]  p1_be_i;
  logic [31:0] p1_wdata_i, p1_rdata_o;
  logic        mem_en_o, mem_we_o, busy_o;
  logic [15:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic [5:0]  ctl;

  int n_cmp = 0;
  int n_err = 0;

  instr_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_gnt_o(p0_gnt_o),
    .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
    .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_lock_i(p1_lock_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  // {p0_gnt, p1_gnt, mem_en, p0_rvalid, p1_rvalid, busy}
  assign ctl = {p0_gnt_o, p1_gnt_o, mem_en_o, p0_rvalid_o, p1_rvalid_o, busy_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: word = boot ROM tag or RAM tag in the upper half, address below
  initial begin
    logic        en;
    logic [15:0] a;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      #2;
      en = mem_en_o;
      a  = mem_addr_o;
      @(posedge clk);
      #1;
      if (en) mem_rdata_i = a[15] ? {16'hB007, a} : {16'h1A5A, a};
    end
  end

  task automatic drive(input logic r0, input logic [15:0] a0, input logic r1,
                       input logic [15:0] a1, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic lk);
    p0_req_i = r0; p0_addr_i = a0;
    p1_req_i = r1; p1_addr_i = a1; p1_we_i = we; p1_be_i = be;
    p1_wdata_i = wd; p1_lock_i = lk;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 16'h0, 0, 16'h0, 0, 4'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1;
      drive(1, 16'h0004, 1, 16'h0008, 0, 4'hF, 32'h0, 1);
      #1;
      n_cmp++;
      if (ctl !== 6'b000000) begin
        n_err++;
        $display("FAIL reset_ctl c=%0d: got %b want 000000", c, ctl);
      end
    end
    apply_reset();
  endtask

  task automatic test_p0_stream();
    logic [5:0] exp_ctl [5];
    exp_ctl = '{6'b101000, 6'b101101, 6'b101101, 6'b000101, 6'b000000};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(c < 3, 16'(4 * c), 0, 16'h0, 0, 4'h0, 32'h0, 0);
      #1;
      n_cmp++;
      if (ctl !== exp_ctl[c]) begin
        n_err++;
        $display("FAIL p0_stream_ctl c=%0d: got %b want %b", c, ctl, exp_ctl[c]);
      end
      if (c < 3) begin
        n_cmp++;
        if ({mem_we_o, mem_be_o, mem_addr_o} !== {1'b0, 4'hF, 16'(4 * c)}) begin
          n_err++;
          $display("FAIL p0_stream_req c=%0d: got %h want %h", c,
                   {mem_we_o, mem_be_o, mem_addr_o}, {1'b0, 4'hF, 16'(4 * c)});
        end
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (p0_rdata_o !== 32'h1A5A0000 + 32'(4 * (c - 1))) begin
          n_err++;
          $display("FAIL p0_stream_rdata c=%0d: got %h want %h", c, p0_rdata_o,
                   32'h1A5A0000 + 32'(4 * (c - 1)));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [5:0]  exp_ctl  [5];
    logic [20:0] exp_req  [4];
    logic [31:0] exp_data [5];
    exp_ctl  = '{6'b101000, 6'b011101, 6'b101011, 6'b011101, 6'b000011};
    exp_req  = '{{1'b0, 4'hF, 16'h0010}, {1'b0, 4'h3, 16'h0020},
                 {1'b0, 4'hF, 16'h0010}, {1'b0, 4'h3, 16'h0020}};
    exp_data = '{32'h0, 32'h1A5A0010, 32'h1A5A0020, 32'h1A5A0010, 32'h1A5A0020};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(c < 4, 16'h0010, c < 4, 16'h0020, 0, 4'h3, 32'h0, 0);
      #1;
      n_cmp++;
      if (ctl !== exp_ctl[c]) begin
        n_err++;
        $display("FAIL rr_ctl c=%0d: got %b want %b", c, ctl, exp_ctl[c]);
      end
      if (c < 4) begin
        n_cmp++;
        if ({mem_we_o, mem_be_o, mem_addr_o} !== exp_req[c]) begin
          n_err++;
          $display("FAIL rr_req c=%0d: got %h want %h", c,
                   {mem_we_o, mem_be_o, mem_addr_o}, exp_req[c]);
        end
      end
      if (c >= 1) begin
        n_cmp++;
        if (((c % 2 == 1) ? p0_rdata_o : p1_rdata_o) !== exp_data[c]) begin
          n_err++;
          $display("FAIL rr_rdata c=%0d: got %h want %h", c,
                   (c % 2 == 1) ? p0_rdata_o : p1_rdata_o, exp_data[c]);
        end
      end
    end
  endtask

  task automatic test_lock_burst();
    logic [5:0] exp_c;
    int         p1_cnt = 0;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 10) drive(c >= 1, 16'h0000, 1, 16'h0040, 1, 4'hF, 32'hDEADBEEF, 1);
      else        drive(0, 16'h0, 0, 16'h0, 0, 4'h0, 32'h0, 0);
      #1;
      exp_c = (c == 0) ? 6'b011000 : (c <= 8) ? 6'b011011 :
              (c == 9) ? 6'b101011 : 6'b000101;
      n_cmp++;
      if (ctl !== exp_c) begin
        n_err++;
        $display("FAIL lock_burst_ctl c=%0d: got %b want %b", c, ctl, exp_c);
      end
      if (c >= 1 && c <= 9 && p1_gnt_o) p1_cnt++;
      if (c >= 1 && c <= 8) begin
        n_cmp++;
        if ({mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o} !==
            {1'b1, 4'hF, 32'hDEADBEEF, 16'h0040}) begin
          n_err++;
          $display("FAIL lock_burst_wr c=%0d: got %h want 1fdeadbeef0040", c,
                   {mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o});
        end
      end
    end
    n_cmp++;
    if (p1_cnt !== 8) begin
      n_err++;
      $display("FAIL lock_burst_count: got %0d p1 grants want 8", p1_cnt);
    end
  endtask

  task automatic test_lock_idle();
    logic [5:0] exp_c;
    int         n_idle = 0;
    int         n_cont = 0;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c < 29) drive(c >= 20, 16'h0000, 1, 16'h0080, 0, 4'hF, 32'h0, 1);
      else        drive(0, 16'h0, 0, 16'h0, 0, 4'h0, 32'h0, 0);
      #1;
      exp_c = (c == 0) ? 6'b011000 : (c < 28) ? 6'b011011 :
              (c == 28) ? 6'b101011 : 6'b000101;
      n_cmp++;
      if (ctl !== exp_c) begin
        n_err++;
        $display("FAIL lock_idle_ctl c=%0d: got %b want %b", c, ctl, exp_c);
      end
      if (c < 20 && p1_gnt_o) n_idle++;
      if (c >= 20 && c <= 28 && p1_gnt_o) n_cont++;
      if (c == 19) begin
        n_cmp++;
        if (dut.burst_cnt_q !== 4'd0) begin
          n_err++;
          $display("FAIL lock_idle_counter: got %0d want 0", dut.burst_cnt_q);
        end
      end
    end
    n_cmp++;
    if (n_idle !== 20 || n_cont !== 8) begin
      n_err++;
      $display("FAIL lock_idle_count: got %0d/%0d p1 grants want 20/8", n_idle, n_cont);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_ctl [4];
    exp_ctl = '{6'b101000, 6'b000000, 6'b101000, 6'b000101};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst = (c == 1);
      if (c == 0)      drive(1, 16'h0008, 0, 16'h0, 0, 4'h0, 32'h0, 0);
      else if (c == 2) drive(1, 16'h0008, 1, 16'h0020, 0, 4'hF, 32'h0, 0);
      else             drive(0, 16'h0, 0, 16'h0, 0, 4'h0, 32'h0, 0);
      #1;
      n_cmp++;
      if (ctl !== exp_ctl[c]) begin
        n_err++;
        $display("FAIL reset_mid_ctl c=%0d: got %b want %b", c, ctl, exp_ctl[c]);
      end
    end
  endtask

  task automatic test_boot_read();
    @(negedge clk);
    drive(0, 16'h0, 1, 16'h8010, 0, 4'hF, 32'h0, 0);
    #1;
    n_cmp++;
    if (ctl !== 6'b011000) begin
      n_err++;
      $display("FAIL boot_ctl0: got %b want 011000", ctl);
    end
    n_cmp++;
    if ({mem_we_o, mem_addr_o} !== {1'b0, 16'h8010}) begin
      n_err++;
      $display("FAIL boot_addr: got %h want 08010", {mem_we_o, mem_addr_o});
    end
    @(negedge clk);
    drive(0, 16'h0, 0, 16'h0, 0, 4'h0, 32'h0, 0);
    #1;
    n_cmp++;
    if (ctl !== 6'b000011) begin
      n_err++;
      $display("FAIL boot_ctl1: got %b want 000011", ctl);
    end
    n_cmp++;
    if ({p1_rdata_o, p0_rdata_o} !== {32'hB0078010, 32'hB0078010}) begin
      n_err++;
      $display("FAIL boot_rdata: got %h/%h want b0078010/b0078010", p1_rdata_o, p0_rdata_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 16'h0, 0, 16'h0, 0, 4'h0, 32'h0, 0);
    test_reset();
    test_p0_stream();
    test_round_robin();
    test_lock_burst();
    test_lock_idle();
    test_reset_mid();
    test_boot_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
